// File: rtl/arp_server_hls_deadlock_reporter_pkg.sv
// ---------------------------------------------------------------------------
// arp_server_hls_deadlock_reporter_pkg
// Shared types and constants for the ARP server deadlock reporter:
//   - reporter FSM state encoding
//   - report kind codes
//   - report field offsets/widths derived from NUM_PROC / NUM_AXIS / CNT_W
//   - helper that clamps the confirm-time duration into the counter width
// No ports (package).
// ---------------------------------------------------------------------------
package arp_server_hls_deadlock_reporter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_RPT_ON  = 3'd2,
    ST_HELD    = 3'd3,
    ST_RPT_OFF = 3'd4
  } state_e;

  localparam logic RPT_KIND_ASSERT  = 1'b0;
  localparam logic RPT_KIND_RELEASE = 1'b1;

  // Default geometry
  localparam int unsigned DEF_NUM_PROC = 32'd5;
  localparam int unsigned DEF_NUM_AXIS = 32'd4;
  localparam int unsigned DEF_CNT_W    = 32'd32;

  // Record layout, LSB upwards: idle_snap, block_snap, axis_snap, duration, kind
  function automatic int unsigned rpt_idle_lsb();
    return 32'd0;
  endfunction

  function automatic int unsigned rpt_block_lsb(input int unsigned np);
    return np;
  endfunction

  function automatic int unsigned rpt_axis_lsb(input int unsigned np);
    return 32'd2 * np;
  endfunction

  function automatic int unsigned rpt_dur_lsb(input int unsigned np, input int unsigned na);
    return (32'd2 * np) + na;
  endfunction

  function automatic int unsigned rpt_kind_bit(input int unsigned np, input int unsigned na,
                                               input int unsigned cw);
    return (32'd2 * np) + na + cw;
  endfunction

  function automatic int unsigned rpt_width(input int unsigned np, input int unsigned na,
                                            input int unsigned cw);
    return (32'd2 * np) + na + cw + 32'd1;
  endfunction

  localparam int unsigned DEF_RPT_W = rpt_width(DEF_NUM_PROC, DEF_NUM_AXIS, DEF_CNT_W);

  // Duration loaded at confirm, saturated to what a cw-bit counter can hold.
  // CONFIRM_CYCLES is at most 255, so any counter of 8 bits or more holds it.
  function automatic int unsigned dur_init(input int unsigned c, input int unsigned cw);
    int unsigned lim;
    if (cw >= 32'd8) begin
      return c;
    end
    lim = (32'd1 << cw) - 32'd1;
    return (c > lim) ? lim : c;
  endfunction

endpackage

// File: rtl/arp_server_hls_deadlock_reporter_qual.sv
// ---------------------------------------------------------------------------
// arp_server_hls_deadlock_qual
// Consecutive-sample qualifier for the monitor's block indication.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset
//   i_en               : qualifier armed (reporter in IDLE or CONFIRM)
//   i_sample           : raw block indication
//   o_confirm          : pulse, this sample completes CONFIRM_CYCLES highs
//   o_drop             : pulse, a run of highs was broken by a low sample
// ---------------------------------------------------------------------------
module arp_server_hls_deadlock_qual #(
  parameter int unsigned CONFIRM_CYCLES = 32'd16
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_sample,
  output logic o_confirm,
  output logic o_drop
);

  // Count of highs already seen; the current high sample is the (r_cnt+1)-th.
  localparam logic [7:0] LAST = 8'(CONFIRM_CYCLES - 32'd1);

  logic [7:0] r_cnt;

  assign o_confirm = i_en & i_sample & (r_cnt == LAST);
  assign o_drop    = i_en & ~i_sample & (r_cnt != 8'd0);

  // Run-length counter; cleared whenever disarmed, broken, or confirmed.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= 8'd0;
    end else if (!i_en || !i_sample || o_confirm) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/arp_server_hls_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// arp_server_hls_deadlock_reporter
// Qualifies the dataflow deadlock monitor's block output, snapshots the
// per-process and AXIS block vectors at confirm, and emits an assert record
// and a release record over a valid/ready stream.
// Ports:
//   i_clock, i_reset_n     : clock, async active-low reset
//   i_block_in             : monitor block output
//   i_inst_idle_sigs       : process idle vector        [NUM_PROC]
//   i_inst_block_sigs      : process channel-block vec  [NUM_PROC]
//   i_axis_block_sigs      : AXIS block vector          [NUM_AXIS]
//   o_rpt_valid/i_rpt_ready: record handshake
//   o_rpt_data             : {kind, duration, axis, block, idle}
//   o_deadlock_flag        : sticky, set on confirm, cleared by i_clear
//   i_clear                : clears o_deadlock_flag (confirm wins)
//   o_event_count          : saturating count of confirmed deadlocks
// ---------------------------------------------------------------------------
module arp_server_hls_deadlock_reporter
  import arp_server_hls_deadlock_reporter_pkg::*;
#(
  parameter int unsigned NUM_PROC       = 32'd5,
  parameter int unsigned NUM_AXIS       = 32'd4,
  parameter int unsigned CONFIRM_CYCLES = 32'd16,
  parameter int unsigned CNT_W          = 32'd32
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset_n,
  input  logic                                     i_block_in,
  input  logic [NUM_PROC-1:0]                      i_inst_idle_sigs,
  input  logic [NUM_PROC-1:0]                      i_inst_block_sigs,
  input  logic [NUM_AXIS-1:0]                      i_axis_block_sigs,
  output logic                                     o_rpt_valid,
  input  logic                                     i_rpt_ready,
  output logic [CNT_W+NUM_AXIS+2*NUM_PROC:0]       o_rpt_data,
  output logic                                     o_deadlock_flag,
  input  logic                                     i_clear,
  output logic [15:0]                              o_event_count
);

  localparam logic [CNT_W-1:0] DUR_INIT = CNT_W'(dur_init(CONFIRM_CYCLES, CNT_W));
  localparam logic [CNT_W-1:0] DUR_MAX  = {CNT_W{1'b1}};

  state_e                       r_state;
  state_e                       w_next_state;
  logic                         w_qual_en;
  logic                         w_confirm;
  logic                         w_drop;
  logic                         w_load_rel;
  logic                         w_dur_inc;
  logic [CNT_W-1:0]             r_dur;
  logic                         r_rel_pend;
  logic [NUM_PROC-1:0]          r_idle_snap;
  logic [NUM_PROC-1:0]          r_block_snap;
  logic [NUM_AXIS-1:0]          r_axis_snap;
  logic                         r_valid;
  logic [CNT_W+NUM_AXIS+2*NUM_PROC:0] r_data;
  logic                         r_flag;
  logic [15:0]                  r_evt;

  assign w_qual_en = (r_state == ST_IDLE) || (r_state == ST_CONFIRM);

  arp_server_hls_deadlock_qual #(
    .CONFIRM_CYCLES (CONFIRM_CYCLES)
  ) u_qual (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_en      (w_qual_en),
    .i_sample  (i_block_in),
    .o_confirm (w_confirm),
    .o_drop    (w_drop)
  );

  // Next-state logic. A low sample on the RPT_ON handshake cycle is treated
  // as a release, so HELD is never entered with the deadlock already gone.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_confirm)       w_next_state = ST_RPT_ON;
        else if (i_block_in) w_next_state = ST_CONFIRM;
        else                 w_next_state = ST_IDLE;
      end
      ST_CONFIRM: begin
        if (w_confirm)    w_next_state = ST_RPT_ON;
        else if (w_drop)  w_next_state = ST_IDLE;
        else              w_next_state = ST_CONFIRM;
      end
      ST_RPT_ON: begin
        if (i_rpt_ready) w_next_state = (r_rel_pend || !i_block_in) ? ST_RPT_OFF : ST_HELD;
        else             w_next_state = ST_RPT_ON;
      end
      ST_HELD: begin
        if (!i_block_in) w_next_state = ST_RPT_OFF;
        else             w_next_state = ST_HELD;
      end
      ST_RPT_OFF: begin
        if (i_rpt_ready) w_next_state = ST_IDLE;
        else             w_next_state = ST_RPT_OFF;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_load_rel = (w_next_state == ST_RPT_OFF) && (r_state != ST_RPT_OFF);
  // Duration keeps running through RPT_ON until the first low sample there.
  assign w_dur_inc  = i_block_in &&
                      (((r_state == ST_RPT_ON) && !r_rel_pend) || (r_state == ST_HELD));

  // State register and record-valid register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= (w_next_state == ST_RPT_ON) || (w_next_state == ST_RPT_OFF);
    end
  end

  // Live duration counter and latched release.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dur      <= {CNT_W{1'b0}};
      r_rel_pend <= 1'b0;
    end else begin
      if (w_confirm) begin
        r_dur <= DUR_INIT;
      end else if (w_dur_inc && (r_dur != DUR_MAX)) begin
        r_dur <= r_dur + CNT_W'(1);
      end
      if ((r_state == ST_RPT_ON) && !i_block_in) begin
        r_rel_pend <= 1'b1;
      end else if ((r_state == ST_RPT_OFF) && i_rpt_ready) begin
        r_rel_pend <= 1'b0;
      end
    end
  end

  // Snapshots and the outgoing record; data only changes on record load.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idle_snap  <= {NUM_PROC{1'b0}};
      r_block_snap <= {NUM_PROC{1'b0}};
      r_axis_snap  <= {NUM_AXIS{1'b0}};
      r_data       <= '0;
    end else if (w_confirm) begin
      r_idle_snap  <= i_inst_idle_sigs;
      r_block_snap <= i_inst_block_sigs;
      r_axis_snap  <= i_axis_block_sigs;
      r_data       <= {RPT_KIND_ASSERT, DUR_INIT, i_axis_block_sigs,
                       i_inst_block_sigs, i_inst_idle_sigs};
    end else if (w_load_rel) begin
      r_data       <= {RPT_KIND_RELEASE, r_dur, r_axis_snap, r_block_snap, r_idle_snap};
    end
  end

  // Sticky flag (confirm beats clear) and saturating event counter.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_flag <= 1'b0;
      r_evt  <= 16'd0;
    end else begin
      if (w_confirm)    r_flag <= 1'b1;
      else if (i_clear) r_flag <= 1'b0;
      if (w_confirm && (r_evt != 16'hFFFF)) begin
        r_evt <= r_evt + 16'd1;
      end
    end
  end

  assign o_rpt_valid     = r_valid;
  assign o_rpt_data      = r_data;
  assign o_deadlock_flag = r_flag;
  assign o_event_count   = r_evt;

endmodule

// File: tb/tb_arp_server_hls_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// tb_arp_server_hls_deadlock_reporter
// Table-driven check of the deadlock reporter at default parameters, plus
// hand-written sequences for reset during a pending record and for duration
// saturation (second instance with CNT_W=4, CONFIRM_CYCLES=1).
// ---------------------------------------------------------------------------
module tb_arp_server_hls_deadlock_reporter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blk_in;
  logic [4:0]  idle_v;
  logic [4:0]  bsig_v;
  logic [3:0]  axis_v;
  logic        rdy;
  logic        clr;

  logic        m_valid;
  logic [46:0] m_data;
  logic        m_flag;
  logic [15:0] m_cnt;

  logic        s_valid;
  logic [18:0] s_data;
  logic        s_flag;
  logic [15:0] s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] A_IDLE = 5'h01;
  localparam logic [4:0] A_BSIG = 5'h02;
  localparam logic [3:0] A_AXIS = 4'h3;
  localparam logic [4:0] B_IDLE = 5'h15;
  localparam logic [4:0] B_BSIG = 5'h0A;
  localparam logic [3:0] B_AXIS = 4'hC;

  always #5 clk = ~clk;

  arp_server_hls_deadlock_reporter u_dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_block_in        (blk_in),
    .i_inst_idle_sigs  (idle_v),
    .i_inst_block_sigs (bsig_v),
    .i_axis_block_sigs (axis_v),
    .o_rpt_valid       (m_valid),
    .i_rpt_ready       (rdy),
    .o_rpt_data        (m_data),
    .o_deadlock_flag   (m_flag),
    .i_clear           (clr),
    .o_event_count     (m_cnt)
  );

  arp_server_hls_deadlock_reporter #(
    .NUM_PROC       (32'd5),
    .NUM_AXIS       (32'd4),
    .CONFIRM_CYCLES (32'd1),
    .CNT_W          (32'd4)
  ) u_sat (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_block_in        (blk_in),
    .i_inst_idle_sigs  (idle_v),
    .i_inst_block_sigs (bsig_v),
    .i_axis_block_sigs (axis_v),
    .o_rpt_valid       (s_valid),
    .i_rpt_ready       (rdy),
    .o_rpt_data        (s_data),
    .o_deadlock_flag   (s_flag),
    .i_clear           (clr),
    .o_event_count     (s_cnt)
  );

  typedef struct {
    int          n;
    logic        b;
    logic        use_b;
    logic        r;
    logic        c;
    logic        e_valid;
    logic [46:0] e_data;
    logic        e_flag;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic logic [46:0] rec(input logic kind, input logic [31:0] dur);
    return {kind, dur, B_AXIS, B_BSIG, B_IDLE};
  endfunction

  function automatic logic [18:0] srec(input logic kind, input logic [3:0] dur);
    return {kind, dur, B_AXIS, B_BSIG, B_IDLE};
  endfunction

  function automatic vec_t mk(input int n, input logic b, input logic use_b, input logic r,
                              input logic c, input logic ev, input logic [46:0] ed,
                              input logic ef, input logic [15:0] ec);
    vec_t v;
    v.n = n; v.b = b; v.use_b = use_b; v.r = r; v.c = c;
    v.e_valid = ev; v.e_data = ed; v.e_flag = ef; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic use_b, input logic r, input logic c);
    blk_in = b;
    idle_v = use_b ? B_IDLE : A_IDLE;
    bsig_v = use_b ? B_BSIG : A_BSIG;
    axis_v = use_b ? B_AXIS : A_AXIS;
    rdy    = r;
    clr    = c;
  endtask

  // One clock: inputs already set at a falling edge, sample outputs at the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            n   b     B     rdy   clr   valid data            flag  cnt
    tbl[0]  = mk(15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b0, 16'd0);
    tbl[1]  = mk(2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b0, 16'd0);
    tbl[2]  = mk(15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b0, 16'd0);
    tbl[3]  = mk(1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rec(1'b0, 32'd16), 1'b1, 16'd1);
    tbl[4]  = mk(1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd1);
    tbl[5]  = mk(23, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd1);
    tbl[6]  = mk(1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rec(1'b1, 32'd40), 1'b1, 16'd1);
    tbl[7]  = mk(3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rec(1'b1, 32'd40), 1'b1, 16'd1);
    tbl[8]  = mk(1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd1);
    tbl[9]  = mk(2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd1);
    tbl[10] = mk(1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 47'd0,           1'b0, 16'd1);
    tbl[11] = mk(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 47'd0,           1'b0, 16'd1);
    tbl[12] = mk(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rec(1'b0, 32'd16), 1'b1, 16'd2);
    tbl[13] = mk(2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rec(1'b0, 32'd16), 1'b1, 16'd2);
    tbl[14] = mk(8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rec(1'b0, 32'd16), 1'b1, 16'd2);
    tbl[15] = mk(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, rec(1'b1, 32'd18), 1'b1, 16'd2);
    tbl[16] = mk(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd2);
    tbl[17] = mk(2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd2);
    tbl[18] = mk(15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 47'd0,           1'b0, 16'd2);
    tbl[19] = mk(1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, rec(1'b0, 32'd16), 1'b1, 16'd3);
    tbl[20] = mk(1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rec(1'b1, 32'd16), 1'b1, 16'd3);
    tbl[21] = mk(1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 47'd0,           1'b1, 16'd3);
    tbl[22] = mk(1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 47'd0,           1'b0, 16'd3);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset valid", {63'd0, m_valid}, 64'd0);
    check("reset data",  {17'd0, m_data}, 64'd0);
    check("reset flag",  {63'd0, m_flag}, 64'd0);
    check("reset count", {48'd0, m_cnt}, 64'd0);
    rst_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        drive(tbl[r].b, tbl[r].use_b, tbl[r].r, tbl[r].c);
        step();
        check($sformatf("row%0d.%0d valid", r, k), {63'd0, m_valid}, {63'd0, tbl[r].e_valid});
        check($sformatf("row%0d.%0d flag", r, k),  {63'd0, m_flag},  {63'd0, tbl[r].e_flag});
        check($sformatf("row%0d.%0d count", r, k), {48'd0, m_cnt},   {48'd0, tbl[r].e_cnt});
        if (tbl[r].e_valid) begin
          check($sformatf("row%0d.%0d data", r, k), {17'd0, m_data}, {17'd0, tbl[r].e_data});
        end
      end
    end

    // Reset while the assert record is waiting for ready.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (16) step();
    check("pre-reset valid", {63'd0, m_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", {63'd0, m_valid}, 64'd0);
    check("async reset data",  {17'd0, m_data}, 64'd0);
    check("async reset flag",  {63'd0, m_flag}, 64'd0);
    check("async reset count", {48'd0, m_cnt}, 64'd0);
    check("async reset sat valid", {63'd0, s_valid}, 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("in-reset valid", {63'd0, m_valid}, 64'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("post-reset valid", {63'd0, m_valid}, 64'd0);
      check("post-reset flag",  {63'd0, m_flag}, 64'd0);
      check("post-reset count", {48'd0, m_cnt}, 64'd0);
    end

    // CONFIRM_CYCLES=1, CNT_W=4: confirm on the first high sample, saturate at 15.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("sat assert valid", {63'd0, s_valid}, 64'd1);
    check("sat assert data",  {45'd0, s_data}, {45'd0, srec(1'b0, 4'd1)});
    check("sat count",        {48'd0, s_cnt}, 64'd1);
    check("sat flag",         {63'd0, s_flag}, 64'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("sat held valid", {63'd0, s_valid}, 64'd0);
    repeat (28) step();
    check("sat held valid end", {63'd0, s_valid}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("sat release valid", {63'd0, s_valid}, 64'd1);
    check("sat release data",  {45'd0, s_data}, {45'd0, srec(1'b1, 4'd15)});
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("sat done valid", {63'd0, s_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
